// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded grant length.
// A grant is held while the owner keeps requesting, up to MAX_HOLD cycles, then forcibly released.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout,
    output logic [7:0] hold_cnt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] pick;
    logic       found;

    logic [7:0] gnt_nxt;
    logic [2:0] idx_nxt;
    logic       vld_nxt;
    logic       to_nxt;
    logic [7:0] hold_nxt;

    // Scan from farthest to nearest so the requester closest to ptr wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                pick  = ptr + 3'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = 8'd0;
        idx_nxt   = 3'd0;
        vld_nxt   = 1'b0;
        to_nxt    = 1'b0;
        hold_nxt  = 8'd0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick;
                    vld_nxt   = 1'b1;
                    gnt_nxt   = 8'b1 << pick;
                    hold_nxt  = 8'd1;
                end
            end
            GRANT: begin
                // A voluntary release takes precedence over the hold limit, so no timeout then.
                if (!req[gnt_idx]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + 3'd1;
                end else if (hold_cnt == 8'(MAX_HOLD)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + 3'd1;
                    to_nxt    = 1'b1;
                end else begin
                    idx_nxt  = gnt_idx;
                    vld_nxt  = 1'b1;
                    gnt_nxt  = gnt;
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            gnt      <= 8'd0;
            gnt_idx  <= 3'd0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= idx_nxt;
            gnt_vld  <= vld_nxt;
            timeout  <= to_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: two instances (MAX_HOLD 4 and 2) share stimulus
// and are compared every cycle against a behavioural owner/ptr model.
module tb_rr_arbiter8;

    localparam int MH0 = 4;
    localparam int MH1 = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;

    logic [7:0] gnt_o  [2];
    logic [2:0] idx_o  [2];
    logic       vld_o  [2];
    logic       to_o   [2];
    logic [7:0] hold_o [2];

    int checks = 0;
    int errors = 0;

    int owner   [2];
    int held    [2];
    int ptrM    [2];
    int toM     [2];
    int maxHold [2] = '{MH0, MH1};

    rr_arbiter8 #(.MAX_HOLD(MH0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt_o[0]), .gnt_idx(idx_o[0]), .gnt_vld(vld_o[0]),
        .timeout(to_o[0]), .hold_cnt(hold_o[0])
    );

    rr_arbiter8 #(.MAX_HOLD(MH1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt_o[1]), .gnt_idx(idx_o[1]), .gnt_vld(vld_o[1]),
        .timeout(to_o[1]), .hold_cnt(hold_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1;
            held[m]  = 0;
            ptrM[m]  = 0;
            toM[m]   = 0;
        end
    endtask

    // One clock edge of the arbitration rules, expressed in terms of who owns the bus.
    task automatic modelStep(input logic [7:0] r, input logic e);
        for (int m = 0; m < 2; m++) begin
            toM[m] = 0;
            if (owner[m] < 0) begin
                if (e && r != 8'd0) begin
                    for (int k = 0; k < 8; k++) begin
                        int i = (ptrM[m] + k) % 8;
                        if (r[i]) begin
                            owner[m] = i;
                            held[m]  = 1;
                            break;
                        end
                    end
                end
            end else if (!r[owner[m]]) begin
                ptrM[m]  = (owner[m] + 1) % 8;
                owner[m] = -1;
                held[m]  = 0;
            end else if (held[m] == maxHold[m]) begin
                ptrM[m]  = (owner[m] + 1) % 8;
                owner[m] = -1;
                held[m]  = 0;
                toM[m]   = 1;
            end else begin
                held[m] = held[m] + 1;
            end
        end
    endtask

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int m = 0; m < 2; m++) begin
            logic [7:0] expGnt;
            logic [7:0] expIdx;
            expGnt = (owner[m] >= 0) ? (8'd1 << owner[m]) : 8'd0;
            expIdx = (owner[m] >= 0) ? 8'(owner[m]) : 8'd0;
            checkOne($sformatf("%s dut%0d gnt", tag, m), gnt_o[m], expGnt);
            checkOne($sformatf("%s dut%0d gnt_idx", tag, m), {5'd0, idx_o[m]}, expIdx);
            checkOne($sformatf("%s dut%0d gnt_vld", tag, m), {7'd0, vld_o[m]}, (owner[m] >= 0) ? 8'd1 : 8'd0);
            checkOne($sformatf("%s dut%0d timeout", tag, m), {7'd0, to_o[m]}, 8'(toM[m]));
            checkOne($sformatf("%s dut%0d hold_cnt", tag, m), hold_o[m], 8'(held[m]));
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic e, input string tag);
        req = r;
        en  = e;
        @(posedge clk);
        modelStep(r, e);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] r;
        logic       e;

        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;

        $display("[TB] single requester");
        applyStimulus(8'h00, 1'b1, "idle_noreq");
        applyStimulus(8'h04, 1'b1, "single_grant");
        applyStimulus(8'h04, 1'b1, "single_hold");
        applyStimulus(8'h00, 1'b1, "single_release");
        applyStimulus(8'h0C, 1'b1, "ptr_after_2");
        applyStimulus(8'h00, 1'b1, "release_3");
        applyStimulus(8'h00, 1'b1, "idle");

        $display("[TB] rotation with all requesting");
        repeat (36) applyStimulus(8'hFF, 1'b1, "rotate");
        applyStimulus(8'h00, 1'b1, "rotate_end");
        applyStimulus(8'h00, 1'b1, "idle");

        $display("[TB] wrap priority");
        applyStimulus(8'h20, 1'b1, "wrap_grant5");
        applyStimulus(8'h00, 1'b1, "wrap_release5");
        applyStimulus(8'h41, 1'b1, "wrap_grant6");
        applyStimulus(8'h00, 1'b1, "wrap_release6");
        applyStimulus(8'h41, 1'b1, "wrap_grant0");
        applyStimulus(8'h00, 1'b1, "wrap_release0");
        applyStimulus(8'h00, 1'b1, "idle");

        $display("[TB] release at hold limit");
        applyStimulus(8'h02, 1'b1, "limit_h1");
        applyStimulus(8'h02, 1'b1, "limit_h2");
        applyStimulus(8'h02, 1'b1, "limit_h3");
        applyStimulus(8'h02, 1'b1, "limit_h4");
        applyStimulus(8'h00, 1'b1, "limit_drop");
        applyStimulus(8'h00, 1'b1, "idle");
        repeat (7) applyStimulus(8'h02, 1'b1, "forced");
        applyStimulus(8'h00, 1'b1, "forced_end");
        applyStimulus(8'h00, 1'b1, "idle");

        $display("[TB] enable gating");
        applyStimulus(8'h08, 1'b1, "en_grant3");
        applyStimulus(8'h08, 1'b0, "en_off_hold");
        applyStimulus(8'hF7, 1'b0, "en_off_release");
        repeat (3) applyStimulus(8'hFF, 1'b0, "en_off_blocked");
        applyStimulus(8'hFF, 1'b1, "en_on_grant4");
        applyStimulus(8'h00, 1'b1, "en_release");
        applyStimulus(8'h00, 1'b1, "idle");

        $display("[TB] reset during grant");
        applyStimulus(8'h20, 1'b1, "rst_h1");
        applyStimulus(8'h20, 1'b1, "rst_h2");
        applyStimulus(8'h20, 1'b1, "rst_h3");
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async");
        #2;
        rst_n = 1'b1;
        applyStimulus(8'hFF, 1'b1, "rst_first_grant0");
        applyStimulus(8'h00, 1'b1, "rst_release");

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            r = 8'($urandom) & 8'($urandom);
            e = ($urandom_range(0, 7) != 0);
            applyStimulus(r, e, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum grant length in cycles (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: arbitration enable; when low, no new grant is issued.
REQ-005 The block SHALL have port req, input, 8 bits: per-requester request; bit i is requester i; level-sensitive; held high for the whole transfer.
REQ-006 The block SHALL have port gnt, output, 8 bits: one-hot grant; all zero when no owner.
REQ-007 The block SHALL have port gnt_idx, output, 3 bits: binary index of the current owner; 0 when no owner.
REQ-008 The block SHALL have port gnt_vld, output, 1 bit: high while any gnt bit is high.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.
REQ-010 The block SHALL have port hold_cnt, output, 8 bits: cycles the current owner has held the grant; 0 when no owner.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-012 The block SHALL keep a 3-bit round-robin pointer ptr giving the highest-priority requester index.
REQ-013 In IDLE with en=1 and req!=0, at the clock edge the block SHALL select the first i with req[i]=1, searching ptr, ptr+1, ... modulo 8, and enter GRANT with gnt_idx=i.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled high in IDLE at edge N gives gnt visible after edge N.
REQ-015 In IDLE with en=0 or req=0, the block SHALL remain in IDLE with all outputs zero.
REQ-016 All outputs SHALL be registered; gnt[i] SHALL be 1 if and only if gnt_vld=1 and gnt_idx=i.
REQ-017 In GRANT, hold_cnt SHALL be 1 in the first grant cycle and increment by 1 each following cycle; it never exceeds MAX_HOLD.
REQ-018 Normal release: in GRANT, when req[gnt_idx]=0 at an edge, the block SHALL go to IDLE, clear gnt, gnt_vld and hold_cnt, set gnt_idx=0, and set ptr=(old gnt_idx+1) mod 8.
REQ-019 Forced release: in GRANT, when hold_cnt=MAX_HOLD and req[gnt_idx]=1 at an edge, the block SHALL do the normal-release actions and assert timeout for exactly the following cycle.
REQ-020 If the owner deasserts req in the same cycle that hold_cnt=MAX_HOLD, the release SHALL be normal, with no timeout pulse.
REQ-021 After any release, gnt SHALL be all zero for at least one cycle (IDLE), so back-to-back grants are separated by exactly one dead cycle when requests are pending.
REQ-022 Deasserting en during GRANT SHALL NOT revoke the current grant; it only blocks the next arbitration.
REQ-023 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration; requests are not latched.
REQ-024 ptr SHALL wrap from 7 to 0; a requester that has just released SHALL have lowest priority at the next arbitration.

Reset
REQ-025 When rst_n=0, the block SHALL immediately, independent of clk, set state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0 and hold_cnt=0.
REQ-026 Reset asserted during GRANT SHALL drop the grant asynchronously, and no timeout pulse SHALL be generated.
REQ-027 After rst_n rises, the first arbitration SHALL occur at the first clock edge with en=1 and req!=0, with ptr=0.

Verification
REQ-028 Single requester: req=8'h04, en=1 -> one cycle later gnt=8'h04, gnt_idx=2, gnt_vld=1, hold_cnt=1; req to 0 -> next cycle gnt=0, ptr=3.
REQ-029 Rotation: req=8'hFF held permanently, MAX_HOLD=2 -> owners 0,1,2,...,7,0, each for 2 cycles; timeout pulses after every grant; exactly one dead cycle between grants.
REQ-030 Wrap priority: ptr=6 after requester 5 releases, req=8'h41 -> grant goes to 6; after 6 releases, req=8'h41 -> grant goes to 0.
REQ-031 Simultaneous release and limit: MAX_HOLD=4, owner drops req in the cycle hold_cnt=4 -> IDLE, timeout stays 0.
REQ-032 en gating: in GRANT to requester 3, en=0, requester 3 releases -> gnt=0 and no new grant while en=0 even with req=8'hFF; en=1 -> grant goes to 4 one cycle later.
REQ-033 Reset mid-grant: owner 5 with hold_cnt=3, rst_n=0 between edges -> gnt=0 and hold_cnt=0 before the next edge; after release of reset with req=8'hFF -> grant goes to 0.
